// File: rtl/prog_int_handler_pkg.sv
// Shared definitions for the Book E program-interrupt entry sequencer:
// SPR numbers, MSR/ESR bit positions (big-endian numbering) and the FSM encoding.
package prog_int_handler_pkg;

  localparam logic [0:9] SPRN_SRR0 = 10'd26;
  localparam logic [0:9] SPRN_SRR1 = 10'd27;
  localparam logic [0:9] SPRN_ESR  = 10'd62;

  localparam int MSR_CE = 14;
  localparam int MSR_ME = 19;
  localparam int MSR_DE = 22;

  localparam int ESR_PIL_BIT = 4;
  localparam int ESR_PPR_BIT = 5;
  localparam int ESR_PTR_BIT = 6;

  // Single set bit at a big-endian index (bit 0 is the MSB).
  function automatic logic [0:31] beBit(input int idx);
    logic [0:31] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  localparam logic [0:31] DEF_MSR_KEEP_MASK = beBit(MSR_CE) | beBit(MSR_ME) | beBit(MSR_DE);
  localparam logic [0:31] DEF_ESR_PIL       = beBit(ESR_PIL_BIT);
  localparam logic [0:31] DEF_ESR_PPR       = beBit(ESR_PPR_BIT);
  localparam logic [0:31] DEF_ESR_PTR       = beBit(ESR_PTR_BIT);

  typedef struct packed {
    logic illegal;
    logic privileged;
    logic trap;
  } progCode_t;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_SRR0,
    SAVE_SRR1,
    SAVE_ESR,
    SET_MSR,
    REDIRECT,
    ACK
  } progState_t;

endpackage

// File: rtl/prog_int_handler_if.sv
// Request/ack handshake plus SPR, MSR and next-PC write ports of the program-interrupt handler.
interface prog_int_handler_if;
  import prog_int_handler_pkg::*;

  logic        progErr;
  progCode_t   progErrCode;
  logic [0:31] excPC;
  logic [0:31] MSR;
  logic [0:31] IVPR;
  logic [0:31] IVOR6;
  logic        ack;
  logic        busy;
  logic        spr_we;
  logic [0:9]  spr_wn;
  logic [0:31] spr_wd;
  logic        msr_we;
  logic [0:31] msr_wd;
  logic        npc_we;
  logic [0:31] npc;

  // Requester / surrounding core side.
  modport master (
    output progErr, progErrCode, excPC, MSR, IVPR, IVOR6,
    input  ack, busy, spr_we, spr_wn, spr_wd, msr_we, msr_wd, npc_we, npc
  );

  // Handler side.
  modport slave (
    input  progErr, progErrCode, excPC, MSR, IVPR, IVOR6,
    output ack, busy, spr_we, spr_wn, spr_wd, msr_we, msr_wd, npc_we, npc
  );

endinterface

// File: rtl/prog_int_esr_enc.sv
// Fixed-priority encoder from the captured cause code to the ESR value saved on entry.
module prog_int_esr_enc
  import prog_int_handler_pkg::*;
#(
  parameter logic [0:31] ESR_PIL = DEF_ESR_PIL,
  parameter logic [0:31] ESR_PPR = DEF_ESR_PPR,
  parameter logic [0:31] ESR_PTR = DEF_ESR_PTR
) (
  input  progCode_t   code,
  output logic [0:31] esr
);

  // A spurious request (no cause bit) still runs the full sequence with ESR=0.
  always_comb begin
    if (code.illegal)         esr = ESR_PIL;
    else if (code.privileged) esr = ESR_PPR;
    else if (code.trap)       esr = ESR_PTR;
    else                      esr = '0;
  end

endmodule

// File: rtl/prog_int_handler.sv
// Program-interrupt entry sequencer: saves SRR0/SRR1/ESR, masks MSR, redirects
// fetch to IVPR||IVOR6 and acks the requester, one step per cycle.
module prog_int_handler
  import prog_int_handler_pkg::*;
#(
  parameter logic [0:31] MSR_KEEP_MASK = DEF_MSR_KEEP_MASK,
  parameter logic [0:31] ESR_PIL       = DEF_ESR_PIL,
  parameter logic [0:31] ESR_PPR       = DEF_ESR_PPR,
  parameter logic [0:31] ESR_PTR       = DEF_ESR_PTR
) (
  input logic              clk,
  input logic              rst,
  prog_int_handler_if.slave bus
);

  progState_t  state;
  progState_t  stateNext;
  progCode_t   codeQ;
  logic [0:31] excPcQ;
  logic [0:31] msrQ;
  logic [0:15] ivprHiQ;
  logic [0:11] ivorMidQ;
  logic [0:31] esrVal;

  prog_int_esr_enc #(
    .ESR_PIL (ESR_PIL),
    .ESR_PPR (ESR_PPR),
    .ESR_PTR (ESR_PTR)
  ) esrEnc (
    .code (codeQ),
    .esr  (esrVal)
  );

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      codeQ    <= '0;
      excPcQ   <= '0;
      msrQ     <= '0;
      ivprHiQ  <= '0;
      ivorMidQ <= '0;
    end else begin
      state <= stateNext;
      // Snapshot everything on entry; later input changes (including our own MSR write) are ignored.
      if (state == IDLE && bus.progErr) begin
        codeQ    <= bus.progErrCode;
        excPcQ   <= bus.excPC;
        msrQ     <= bus.MSR;
        ivprHiQ  <= bus.IVPR[0:15];
        ivorMidQ <= bus.IVOR6[16:27];
      end
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    stateNext  = state;
    bus.ack    = 1'b0;
    bus.busy   = (state != IDLE);
    bus.spr_we = 1'b0;
    bus.spr_wn = '0;
    bus.spr_wd = '0;
    bus.msr_we = 1'b0;
    bus.msr_wd = '0;
    bus.npc_we = 1'b0;
    bus.npc    = '0;

    unique case (state)
      IDLE: begin
        if (bus.progErr) stateNext = SAVE_SRR0;
      end
      SAVE_SRR0: begin
        stateNext  = SAVE_SRR1;
        bus.spr_we = 1'b1;
        bus.spr_wn = SPRN_SRR0;
        bus.spr_wd = excPcQ;
      end
      SAVE_SRR1: begin
        stateNext  = SAVE_ESR;
        bus.spr_we = 1'b1;
        bus.spr_wn = SPRN_SRR1;
        bus.spr_wd = msrQ;
      end
      SAVE_ESR: begin
        stateNext  = SET_MSR;
        bus.spr_we = 1'b1;
        bus.spr_wn = SPRN_ESR;
        bus.spr_wd = esrVal;
      end
      SET_MSR: begin
        stateNext  = REDIRECT;
        bus.msr_we = 1'b1;
        bus.msr_wd = msrQ & MSR_KEEP_MASK;
      end
      REDIRECT: begin
        stateNext  = ACK;
        bus.npc_we = 1'b1;
        bus.npc    = {ivprHiQ, ivorMidQ, 4'b0000};
      end
      ACK: begin
        stateNext = IDLE;
        bus.ack   = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_int_handler.sv
// Scoreboard bench for prog_int_handler: stimulus pushes expected writes with their
// cycle numbers, a negedge monitor pops and compares every strobe the DUT raises.
module tb_prog_int_handler;
  import prog_int_handler_pkg::*;

  localparam int K_SPR = 1;
  localparam int K_MSR = 2;
  localparam int K_NPC = 3;
  localparam int K_ACK = 4;

  typedef struct {
    int          kind;
    logic [31:0] wn;
    logic [31:0] data;
    int          cycle;
  } expItem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  expItem_t sb[$];

  prog_int_handler_if bus ();

  prog_int_handler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Monitor: cycle index = edges seen so far + 1.
  always @(negedge clk) begin
    int       nAct;
    expItem_t obs;
    expItem_t want;
    nAct = int'(bus.spr_we) + int'(bus.msr_we) + int'(bus.npc_we) + int'(bus.ack);
    if (nAct > 0) begin
      check("one_strobe", nAct, 1);
      obs.cycle = cyc + 1;
      if (bus.spr_we)      begin obs.kind = K_SPR; obs.wn = 32'(bus.spr_wn); obs.data = bus.spr_wd; end
      else if (bus.msr_we) begin obs.kind = K_MSR; obs.wn = '0; obs.data = bus.msr_wd; end
      else if (bus.npc_we) begin obs.kind = K_NPC; obs.wn = '0; obs.data = bus.npc; end
      else                 begin obs.kind = K_ACK; obs.wn = '0; obs.data = '0; end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual kind=%0d data=%h required none (cycle %0d)",
                 obs.kind, obs.data, obs.cycle);
      end else begin
        want = sb.pop_front();
        check("kind",  obs.kind,  want.kind);
        check("wn",    obs.wn,    want.wn);
        check("data",  obs.data,  want.data);
        check("cycle", obs.cycle, want.cycle);
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] wn, input logic [31:0] data, input int cycle);
    expItem_t e;
    e.kind = kind; e.wn = wn; e.data = data; e.cycle = cycle;
    sb.push_back(e);
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_busy"},   bus.busy,   1'b0);
    check({tag, "_ack"},    bus.ack,    1'b0);
    check({tag, "_spr_we"}, bus.spr_we, 1'b0);
    check({tag, "_msr_we"}, bus.msr_we, 1'b0);
    check({tag, "_npc_we"}, bus.npc_we, 1'b0);
    check({tag, "_spr_wn"}, 32'(bus.spr_wn), 32'h0);
    check({tag, "_spr_wd"}, bus.spr_wd, 32'h0);
    check({tag, "_msr_wd"}, bus.msr_wd, 32'h0);
    check({tag, "_npc"},    bus.npc,    32'h0);
  endtask

  // mode 0: normal, 1: inputs changed and request dropped mid-sequence, 2: rst during SET_MSR.
  task automatic runReq(input logic [2:0] code, input logic [31:0] pc, input logic [31:0] msr,
                        input logic [31:0] ivpr, input logic [31:0] ivor,
                        input logic [31:0] expEsr, input logic [31:0] expMsr,
                        input logic [31:0] expNpc, input int mode);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.progErrCode = code;
    bus.excPC       = pc;
    bus.MSR         = msr;
    bus.IVPR        = ivpr;
    bus.IVOR6       = ivor;
    bus.progErr     = 1'b1;
    n = cyc + 1;
    push(K_SPR, 32'd26, pc,     n + 1);
    push(K_SPR, 32'd27, msr,    n + 2);
    push(K_SPR, 32'd62, expEsr, n + 3);
    push(K_MSR, 32'd0,  expMsr, n + 4);
    if (mode != 2) begin
      push(K_NPC, 32'd0, expNpc, n + 5);
      push(K_ACK, 32'd0, 32'd0,  n + 6);
    end

    if (mode == 1) begin
      while (cyc + 1 < n + 1) @(negedge clk);
      bus.excPC   = 32'hDEAD_0000;
      bus.MSR     = 32'h0000_0000;
      bus.IVPR    = 32'h0000_0000;
      bus.IVOR6   = 32'h0000_0000;
      bus.progErr = 1'b0;
    end

    if (mode == 2) begin
      while (cyc + 1 < n + 4) @(negedge clk);
      rst         = 1'b1;
      bus.progErr = 1'b0;
      @(negedge clk);
      checkIdleOutputs("after_rst");
      rst = 1'b0;
      return;
    end

    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      check("busy_in_seq", bus.busy, 1'b1);
      if (bus.ack) seen = 1;
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
    bus.progErr = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);
    check("ack_width", bus.ack,  1'b0);
  endtask

  initial begin
    bus.progErr     = 1'b0;
    bus.progErrCode = '0;
    bus.excPC       = '0;
    bus.MSR         = '0;
    bus.IVPR        = '0;
    bus.IVOR6       = '0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("idle");

    // Illegal cause
    runReq(3'b100, 32'h0000_1F04, 32'h0002_D230, 32'hFFF0_0000, 32'h0000_0700,
           32'h0800_0000, 32'h0002_1200, 32'hFFF0_0700, 0);
    // Multi-cause priority and single causes
    runReq(3'b111, 32'h0000_2000, 32'hFFFF_FFFF, 32'hFFF0_0000, 32'h0000_0700,
           32'h0800_0000, 32'h0002_1200, 32'hFFF0_0700, 0);
    runReq(3'b011, 32'h0000_3004, 32'h0000_8000, 32'hFFF0_0000, 32'h0000_0700,
           32'h0400_0000, 32'h0000_0000, 32'hFFF0_0700, 0);
    runReq(3'b001, 32'h0000_4008, 32'h0000_1000, 32'hFFF0_0000, 32'h0000_0700,
           32'h0200_0000, 32'h0000_1000, 32'hFFF0_0700, 0);
    // Spurious request
    runReq(3'b000, 32'h0000_500C, 32'h0002_0000, 32'hFFF0_0000, 32'h0000_0700,
           32'h0000_0000, 32'h0002_0000, 32'hFFF0_0700, 0);
    // Vector masking
    runReq(3'b100, 32'h0000_5100, 32'h0000_0000, 32'h1234_ABCD, 32'hFFFF_FFFF,
           32'h0800_0000, 32'h0000_0000, 32'h1234_FFF0, 0);
    // Reset during SET_MSR, then a fresh request restarts cleanly
    runReq(3'b010, 32'h0000_6000, 32'h0002_1200, 32'hFFF0_0000, 32'h0000_0700,
           32'h0400_0000, 32'h0002_1200, 32'hFFF0_0700, 2);
    repeat (2) @(negedge clk);
    checkIdleOutputs("post_rst_idle");
    runReq(3'b001, 32'h0000_6104, 32'h0000_0200, 32'hABCD_0000, 32'h0000_1230,
           32'h0200_0000, 32'h0000_0200, 32'hABCD_1230, 0);
    // Two requests three cycles apart
    repeat (3) @(negedge clk);
    runReq(3'b010, 32'h0000_6208, 32'h0000_0000, 32'h8000_0000, 32'h0000_0100,
           32'h0400_0000, 32'h0000_0000, 32'h8000_0100, 0);
    // Inputs changed and request dropped mid-sequence
    runReq(3'b100, 32'h0000_7000, 32'h0002_D230, 32'hFFF0_0000, 32'h0000_0700,
           32'h0800_0000, 32'h0002_1200, 32'hFFF0_0700, 1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
